// File: rtl/if_fetch_ctrl_pkg.sv
// ============================================================================
// Module      : if_fetch_ctrl_pkg
// Description : Shared types and constants for the instruction-fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam int          IM_AW            = 10;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_ctrl_fifo2.sv
// ============================================================================
// Module      : fetch_fifo2
// Description : Two-entry {pc,instr} prefetch FIFO; flush overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo2
    import if_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    always_comb begin
        w_pop  = i_pop && (r_count != 2'd0);
        w_push = i_push && ((r_count != 2'd2) || w_pop);
    end

    // Slot 0 is always the head; slot 1 shifts down when the head leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop && (r_count == 2'd2)) begin
                r_slot0 <= r_slot1;
            end
            if (w_push) begin
                if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
                    r_slot0 <= i_data;
                end else begin
                    r_slot1 <= i_data;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_slot0;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction-fetch sequencer with 2-entry prefetch buffer and
//               redirect flush. Optional FETCH_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    input  logic             redir_valid,
    input  logic [31:0]      redir_pc,
    output logic             addr_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam logic [1:0] c_FULL = 2'(BUF_DEPTH);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_addr_err;

    fetch_entry_t w_entry;
    fetch_entry_t w_head;
    logic [1:0]   w_count;
    logic         w_pop;
    logic         w_redir;
    logic         w_full;
    logic         w_fetch;
    logic         w_out_of_window;
    logic [31:0]  w_redir_tgt;

    always_comb begin
        w_pop           = out_valid && out_ready;
        w_redir         = redir_valid && (r_state != BOOT);
        w_full          = (w_count == c_FULL);
        w_fetch         = (r_state == RUN) && en && !redir_valid && (!w_full || w_pop);
        w_out_of_window = (r_pc[31:12] != RESET_PC[31:12]);
        w_redir_tgt     = redir_pc & ~32'd3;
        w_entry.pc      = r_pc;
        w_entry.instr   = im_dout;
    end

    // A redirect freezes the HOLD/RUN transition for its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_addr_err <= 1'b0;
        end else begin
            if (w_fetch && w_out_of_window) begin
                r_addr_err <= 1'b1;
            end
            case (r_state)
                BOOT:    r_state <= RUN;
                RUN:     if (!w_redir && !en) r_state <= HOLD;
                HOLD:    if (!w_redir && en)  r_state <= RUN;
                default: r_state <= BOOT;
            endcase
            if (w_redir) begin
                r_pc <= w_redir_tgt;
            end else if (w_fetch) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    fetch_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign im_addr   = r_pc[IM_AW+1:2];
    assign out_valid = (w_count != 2'd0);
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign addr_err  = r_addr_err;

`ifdef FETCH_PERF_EN
    logic w_stall;
    assign w_stall = (r_state == RUN) && en && !redir_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (w_fetch) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (w_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
// Module      : tb_if_fetch_ctrl
// Description : Self-checking bench for if_fetch_ctrl (directed table plus
//               randomized traffic against a queue-based reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        out_ready = 1'b1;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        addr_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .im_addr     (im_addr),
        .im_dout     (im_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .addr_err    (addr_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hC0DE_0000 | {22'd0, pc[11:2]};
    endfunction

    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_at(32'(i) << 2);
    end
    assign im_dout = mem[im_addr];

    // Reference model: buffered words as a queue, plus boot/hold flags.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc = 32'h3000;
    bit          m_boot = 1'b1;
    bit          m_hold = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_fetches = 32'd0;
    logic [31:0] m_stalls = 32'd0;

    always @(posedge clk) begin
        bit pop;
        bit fetch;
        if (rst) begin
            m_q.delete();
            m_pc = 32'h3000;
            m_boot = 1'b1;
            m_hold = 1'b0;
            m_err = 1'b0;
            m_fetches = 32'd0;
            m_stalls = 32'd0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (redir_valid) begin
            m_q.delete();
            m_pc = {redir_pc[31:2], 2'b00};
        end else begin
            pop   = (m_q.size() > 0) && out_ready;
            fetch = !m_hold && en && ((m_q.size() < 2) || pop);
            if (!m_hold && en && (m_q.size() == 2) && !pop) m_stalls = m_stalls + 32'd1;
            if (pop) void'(m_q.pop_front());
            if (fetch) begin
                m_q.push_back('{m_pc, word_at(m_pc)});
                if (m_pc[31:12] != 20'h00003) m_err = 1'b1;
                m_pc = m_pc + 32'd4;
                m_fetches = m_fetches + 32'd1;
            end
            m_hold = !en;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("model out_pc", out_pc, m_q[0].pc);
            check("model out_instr", out_instr, m_q[0].instr);
        end
        check("model im_addr", 32'(im_addr), 32'(m_pc[11:2]));
        check("model addr_err", 32'(addr_err), 32'(m_err));
`ifdef FETCH_PERF_EN
        check("model perf_fetch_cnt", perf_fetch_cnt, m_fetches);
        check("model perf_stall_cnt", perf_stall_cnt, m_stalls);
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [9:0]  eim;
        logic        eerr;
        logic        chk;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic rd, input logic rv,
                                input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                                input logic [9:0] eim, input logic eerr, input logic chk);
        vec_t v;
        v.rst = r; v.en = e; v.rdy = rd; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eim = eim; v.eerr = eerr; v.chk = chk;
        return v;
    endfunction

    vec_t vt[29];

    initial begin
        logic [31:0] exp_instr;

        // rst en rdy rv rpc | valid pc im err chk
        vt[0]  = mk(1, 1, 1, 0, 32'h0,    0, 32'h0,    10'h000, 0, 1);
        vt[1]  = mk(0, 1, 1, 0, 32'h0,    0, 32'h0,    10'h000, 0, 1);
        vt[2]  = mk(0, 1, 1, 0, 32'h0,    1, 32'h3000, 10'h001, 0, 1);
        vt[3]  = mk(0, 1, 1, 0, 32'h0,    1, 32'h3004, 10'h002, 0, 1);
        vt[4]  = mk(0, 1, 1, 0, 32'h0,    1, 32'h3008, 10'h003, 0, 1);
        vt[5]  = mk(1, 1, 0, 0, 32'h0,    0, 32'h0,    10'h000, 0, 1);
        vt[6]  = mk(0, 1, 0, 0, 32'h0,    0, 32'h0,    10'h000, 0, 1);
        vt[7]  = mk(0, 1, 0, 0, 32'h0,    1, 32'h3000, 10'h001, 0, 1);
        vt[8]  = mk(0, 1, 0, 0, 32'h0,    1, 32'h3000, 10'h002, 0, 1);
        vt[9]  = mk(0, 1, 0, 0, 32'h0,    1, 32'h3000, 10'h002, 0, 1);
        vt[10] = mk(0, 1, 0, 0, 32'h0,    1, 32'h3000, 10'h002, 0, 1);
        vt[11] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3004, 10'h003, 0, 1);
        vt[12] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3008, 10'h004, 0, 1);
        vt[13] = mk(0, 1, 0, 1, 32'h3103, 0, 32'h0,    10'h040, 0, 0);
        vt[14] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3100, 10'h041, 0, 1);
        vt[15] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3104, 10'h042, 0, 1);
        vt[16] = mk(0, 1, 1, 1, 32'h3200, 0, 32'h0,    10'h080, 0, 0);
        vt[17] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3200, 10'h081, 0, 1);
        vt[18] = mk(0, 0, 1, 0, 32'h0,    0, 32'h0,    10'h081, 0, 0);
        vt[19] = mk(0, 0, 1, 0, 32'h0,    0, 32'h0,    10'h081, 0, 0);
        vt[20] = mk(0, 0, 1, 0, 32'h0,    0, 32'h0,    10'h081, 0, 0);
        vt[21] = mk(0, 1, 1, 0, 32'h0,    0, 32'h0,    10'h081, 0, 0);
        vt[22] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3204, 10'h082, 0, 1);
        vt[23] = mk(0, 1, 1, 1, 32'h3FFC, 0, 32'h0,    10'h3FF, 0, 0);
        vt[24] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3FFC, 10'h000, 0, 1);
        vt[25] = mk(0, 1, 1, 0, 32'h0,    1, 32'h4000, 10'h001, 1, 1);
        vt[26] = mk(0, 1, 1, 1, 32'h3000, 0, 32'h0,    10'h000, 1, 0);
        vt[27] = mk(0, 1, 1, 0, 32'h0,    1, 32'h3000, 10'h001, 1, 1);
        vt[28] = mk(1, 1, 1, 0, 32'h0,    0, 32'h0,    10'h000, 0, 1);

        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) begin
            rst         = vt[i].rst;
            en          = vt[i].en;
            out_ready   = vt[i].rdy;
            redir_valid = vt[i].rv;
            redir_pc    = vt[i].rpc;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].ev));
            check($sformatf("vec%0d im_addr", i), 32'(im_addr), 32'(vt[i].eim));
            check($sformatf("vec%0d addr_err", i), 32'(addr_err), 32'(vt[i].eerr));
            if (vt[i].chk) begin
                exp_instr = vt[i].ev ? word_at(vt[i].epc) : 32'h0;
                check($sformatf("vec%0d out_pc", i), out_pc, vt[i].epc);
                check($sformatf("vec%0d out_instr", i), out_instr, exp_instr);
            end
            check_model();
        end

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            en          = ($urandom_range(0, 9) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            redir_valid = ($urandom_range(0, 19) == 0);
            redir_pc    = ($urandom_range(0, 15) == 0) ? $urandom : {20'h00003, 12'($urandom)};
            @(posedge clk);
            #1;
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
